// File: rtl/hazard_tracker.sv
// rtl/hazard_tracker.sv - E/M/W writer scoreboard driving D-stage stall and D/E forwarding selects.
// Youngest matching writer (E > M > W) decides both stall and forwarding; $0 never matches.
module hazard_tracker #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] d_rs,
  input  logic [ADDR_W-1:0] d_rt,
  input  logic [1:0]        d_tuse_rs,
  input  logic [1:0]        d_tuse_rt,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_waddr,
  input  logic [1:0]        d_tnew,
  output logic              stall,
  output logic [1:0]        fwd_d_rs,
  output logic [1:0]        fwd_d_rt,
  output logic [1:0]        fwd_e_rs,
  output logic [1:0]        fwd_e_rt,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              r_e_we, r_m_we, r_w_we;
  logic [ADDR_W-1:0] r_e_waddr, r_m_waddr, r_w_waddr;
  logic [1:0]        r_e_tnew, r_m_tnew, r_w_tnew;
  logic [ADDR_W-1:0] r_e_rs, r_e_rt;
  logic [CNT_W-1:0]  r_stall_cnt;

  // Returns the youngest matching stage using the forwarding code: 01 E, 10 M, 11 W, 00 none.
  function automatic logic [1:0] fn_sel(
    input logic [ADDR_W-1:0] r,
    input logic e_we, input logic [ADDR_W-1:0] e_a,
    input logic m_we, input logic [ADDR_W-1:0] m_a,
    input logic w_we, input logic [ADDR_W-1:0] w_a
  );
    if (r == '0)                 return 2'b00;
    else if (e_we && e_a == r)   return 2'b01;
    else if (m_we && m_a == r)   return 2'b10;
    else if (w_we && w_a == r)   return 2'b11;
    else                         return 2'b00;
  endfunction

  function automatic logic [1:0] fn_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  logic [1:0] w_d_rs_sel, w_d_rt_sel, w_e_rs_sel, w_e_rt_sel;
  logic [1:0] w_d_rs_tnew, w_d_rt_tnew, w_e_rs_tnew, w_e_rt_tnew;
  logic       w_stall_rs, w_stall_rt, w_stall;

  assign w_d_rs_sel = fn_sel(d_rs, r_e_we, r_e_waddr, r_m_we, r_m_waddr, r_w_we, r_w_waddr);
  assign w_d_rt_sel = fn_sel(d_rt, r_e_we, r_e_waddr, r_m_we, r_m_waddr, r_w_we, r_w_waddr);
  // The E-stage consumer can only take values from older stages, so its own entry is masked.
  assign w_e_rs_sel = fn_sel(r_e_rs, 1'b0, '0, r_m_we, r_m_waddr, r_w_we, r_w_waddr);
  assign w_e_rt_sel = fn_sel(r_e_rt, 1'b0, '0, r_m_we, r_m_waddr, r_w_we, r_w_waddr);

  always_comb begin
    w_d_rs_tnew = 2'd0;
    w_d_rt_tnew = 2'd0;
    w_e_rs_tnew = 2'd0;
    w_e_rt_tnew = 2'd0;
    case (w_d_rs_sel)
      2'b01:   w_d_rs_tnew = r_e_tnew;
      2'b10:   w_d_rs_tnew = r_m_tnew;
      2'b11:   w_d_rs_tnew = r_w_tnew;
      default: w_d_rs_tnew = 2'd0;
    endcase
    case (w_d_rt_sel)
      2'b01:   w_d_rt_tnew = r_e_tnew;
      2'b10:   w_d_rt_tnew = r_m_tnew;
      2'b11:   w_d_rt_tnew = r_w_tnew;
      default: w_d_rt_tnew = 2'd0;
    endcase
    case (w_e_rs_sel)
      2'b10:   w_e_rs_tnew = r_m_tnew;
      2'b11:   w_e_rs_tnew = r_w_tnew;
      default: w_e_rs_tnew = 2'd0;
    endcase
    case (w_e_rt_sel)
      2'b10:   w_e_rt_tnew = r_m_tnew;
      2'b11:   w_e_rt_tnew = r_w_tnew;
      default: w_e_rt_tnew = 2'd0;
    endcase
  end

  assign w_stall_rs = (d_tuse_rs != 2'b11) && (w_d_rs_sel != 2'b00) && (w_d_rs_tnew > d_tuse_rs);
  assign w_stall_rt = (d_tuse_rt != 2'b11) && (w_d_rt_sel != 2'b00) && (w_d_rt_tnew > d_tuse_rt);
  assign w_stall    = w_stall_rs | w_stall_rt;

  assign stall     = w_stall;
  assign fwd_d_rs  = (w_d_rs_tnew == 2'd0) ? w_d_rs_sel : 2'b00;
  assign fwd_d_rt  = (w_d_rt_tnew == 2'd0) ? w_d_rt_sel : 2'b00;
  assign fwd_e_rs  = (w_e_rs_tnew == 2'd0) ? w_e_rs_sel : 2'b00;
  assign fwd_e_rt  = (w_e_rt_tnew == 2'd0) ? w_e_rt_sel : 2'b00;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_e_we      <= 1'b0;
      r_e_waddr   <= '0;
      r_e_tnew    <= 2'd0;
      r_e_rs      <= '0;
      r_e_rt      <= '0;
      r_m_we      <= 1'b0;
      r_m_waddr   <= '0;
      r_m_tnew    <= 2'd0;
      r_w_we      <= 1'b0;
      r_w_waddr   <= '0;
      r_w_tnew    <= 2'd0;
      r_stall_cnt <= '0;
    end else begin
      r_w_we    <= r_m_we;
      r_w_waddr <= r_m_waddr;
      r_w_tnew  <= fn_dec(r_m_tnew);
      r_m_we    <= r_e_we;
      r_m_waddr <= r_e_waddr;
      r_m_tnew  <= fn_dec(r_e_tnew);
      if (w_stall) begin
        r_e_we      <= 1'b0;
        r_e_waddr   <= '0;
        r_e_tnew    <= 2'd0;
        r_e_rs      <= '0;
        r_e_rt      <= '0;
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end else begin
        r_e_we    <= d_we;
        r_e_waddr <= d_waddr;
        r_e_tnew  <= d_tnew;
        r_e_rs    <= d_rs;
        r_e_rt    <= d_rt;
      end
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// tb/tb_hazard_tracker.sv - directed scenario checks for hazard_tracker.
module tb_hazard_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs, d_rt, d_waddr;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        d_we;
  logic        stall;
  logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  logic [31:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_cnt;

  hazard_tracker #(.ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_we(d_we), .d_waddr(d_waddr), .d_tnew(d_tnew),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tu_rs,
                       input logic [1:0] tu_rt, input logic we, input logic [4:0] wa,
                       input logic [1:0] tn);
    d_rs = rs; d_rt = rt; d_tuse_rs = tu_rs; d_tuse_rt = tu_rt;
    d_we = we; d_waddr = wa; d_tnew = tn;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    set_d(5'd0, 5'd0, 2'b11, 2'b11, 1'b0, 5'd0, 2'd0);
    repeat (3) next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_d(5'd0, 5'd0, 2'b11, 2'b11, 1'b0, 5'd0, 2'd0);
    #12;
    n_tests++;
    if ({stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt} !== 9'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 0", {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt});
    end
    n_tests++;
    if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    reset = 1'b1;
    exp_cnt = 32'd0;
  endtask

  task automatic test_load_use();
    flush();
    set_d(5'd0, 5'd0, 2'b11, 2'b11, 1'b1, 5'd8, 2'd2);
    #1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_lw_nostall: got %b want 0", stall); end
    next_cycle();
    set_d(5'd8, 5'd9, 2'd0, 2'd0, 1'b1, 5'd10, 2'd1);
    #1;
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall1: got %b want 1", stall); end
    next_cycle();
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall2: got %b want 1", stall); end
    next_cycle();
    exp_cnt = exp_cnt + 32'd2;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %b want 0", stall); end
    n_tests++;
    if (fwd_d_rs !== 2'b11) begin n_fail++; $display("FAIL lu_fwd_d_rs: got %b want 11", fwd_d_rs); end
    n_tests++;
    if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL lu_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_alu_chain();
    flush();
    set_d(5'd0, 5'd0, 2'b11, 2'b11, 1'b1, 5'd3, 2'd1);
    next_cycle();
    set_d(5'd3, 5'd0, 2'd1, 2'b11, 1'b1, 5'd4, 2'd1);
    #1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b want 0", stall); end
    n_tests++;
    if (fwd_d_rs !== 2'b00) begin n_fail++; $display("FAIL alu_fwd_d_rs: got %b want 00", fwd_d_rs); end
    next_cycle();
    set_d(5'd0, 5'd0, 2'b11, 2'b11, 1'b0, 5'd0, 2'd0);
    #1;
    n_tests++;
    if (fwd_e_rs !== 2'b10) begin n_fail++; $display("FAIL alu_fwd_e_rs: got %b want 10", fwd_e_rs); end
    n_tests++;
    if (fwd_e_rt !== 2'b00) begin n_fail++; $display("FAIL alu_fwd_e_rt: got %b want 00", fwd_e_rt); end
  endtask

  task automatic test_zero_reg();
    flush();
    set_d(5'd0, 5'd0, 2'b11, 2'b11, 1'b1, 5'd0, 2'd1);
    next_cycle();
    set_d(5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
    #1;
    n_tests++;
    if ({stall, fwd_d_rs, fwd_d_rt} !== 5'd0) begin
      n_fail++; $display("FAIL zero_reg: got %b want 00000", {stall, fwd_d_rs, fwd_d_rt});
    end
  endtask

  task automatic test_double_writer();
    flush();
    set_d(5'd0, 5'd0, 2'b11, 2'b11, 1'b1, 5'd5, 2'd1);
    next_cycle();
    set_d(5'd0, 5'd0, 2'b11, 2'b11, 1'b1, 5'd5, 2'd2);
    next_cycle();
    set_d(5'd5, 5'd0, 2'd1, 2'b11, 1'b0, 5'd0, 2'd0);
    #1;
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL dw_stall: got %b want 1", stall); end
    n_tests++;
    if (fwd_d_rs !== 2'b00) begin n_fail++; $display("FAIL dw_fwd_d_rs: got %b want 00", fwd_d_rs); end
    next_cycle();
    exp_cnt = exp_cnt + 32'd1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL dw_release: got %b want 0", stall); end
    n_tests++;
    if (fwd_d_rs !== 2'b00) begin n_fail++; $display("FAIL dw_fwd_young: got %b want 00", fwd_d_rs); end
    n_tests++;
    if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL dw_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_jal_jr();
    flush();
    set_d(5'd0, 5'd0, 2'b11, 2'b11, 1'b1, 5'd31, 2'd0);
    next_cycle();
    set_d(5'd31, 5'd0, 2'd0, 2'b11, 1'b0, 5'd0, 2'd0);
    #1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL jr_stall: got %b want 0", stall); end
    n_tests++;
    if (fwd_d_rs !== 2'b01) begin n_fail++; $display("FAIL jr_fwd_d_rs: got %b want 01", fwd_d_rs); end
  endtask

  task automatic test_unused_operand();
    flush();
    set_d(5'd0, 5'd0, 2'b11, 2'b11, 1'b1, 5'd7, 2'd2);
    next_cycle();
    set_d(5'd7, 5'd7, 2'b11, 2'd2, 1'b0, 5'd0, 2'd0);
    #1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL unused_stall: got %b want 0", stall); end
    n_tests++;
    if (fwd_d_rt !== 2'b00) begin n_fail++; $display("FAIL unused_fwd_d_rt: got %b want 00", fwd_d_rt); end
    set_d(5'd7, 5'd7, 2'b11, 2'd1, 1'b0, 5'd0, 2'd0);
    #1;
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL rt_stall: got %b want 1", stall); end
    set_d(5'd0, 5'd0, 2'b11, 2'b11, 1'b0, 5'd0, 2'd0);
    #1;
  endtask

  task automatic test_async_reset();
    flush();
    set_d(5'd0, 5'd0, 2'b11, 2'b11, 1'b1, 5'd8, 2'd2);
    next_cycle();
    set_d(5'd8, 5'd0, 2'd0, 2'b11, 1'b0, 5'd0, 2'd0);
    next_cycle();
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL ar_prestall: got %b want 1", stall); end
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt} !== 9'd0) begin
      n_fail++; $display("FAIL ar_outputs: got %b want 0", {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt});
    end
    n_tests++;
    if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL ar_cnt: got %0d want 0", stall_cnt); end
    @(negedge clk);
    reset = 1'b1;
    set_d(5'd0, 5'd8, 2'b11, 2'd2, 1'b0, 5'd0, 2'd0);
    #1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL ar_sw_stall: got %b want 0", stall); end
    next_cycle();
    n_tests++;
    if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL ar_cnt_after: got %0d want 0", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_chain();
    test_zero_reg();
    test_double_writer();
    test_jal_jr();
    test_unused_operand();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
